// File: rtl/cache_backend_arbiter.sv
// cache_backend_arbiter
//   Shares one backend memory read port between NUM_REQ cache ways. Ways raise
//   a miss on their address stream. A round-robin arbiter picks one way, forwards
//   its tag to memory, and routes the line-fill beats back to that way. Only one
//   miss is in flight at a time.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_addr_tvalid/tdata    per-way miss requests (way i tag at [i*TAGS_WIDTH +: TAGS_WIDTH])
//   req_addr_tready          one-hot acceptance of the winning way (IDLE only)
//   req_data_tvalid/tready   per-way fill beat handshake (DATA only)
//   req_data_tdata           fill beat, broadcast to every way
//   mem_addr_*               memory read request stream
//   mem_data_*               memory fill beat stream
//   grant_id                 way that owns (or last owned) the backend port
//   busy                     high whenever a miss is being serviced
module cache_backend_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TAGS_WIDTH     = 48,
  parameter int CACHE_SIZE     = 512,
  parameter int DATA_PORT_SIZE = 512,
  localparam int GRANT_W       = $clog2(NUM_REQ),
  localparam int BEATS         = CACHE_SIZE / DATA_PORT_SIZE,
  localparam int CNT_W         = $clog2(BEATS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_addr_tvalid,
  input  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata,
  output logic [NUM_REQ-1:0]            req_addr_tready,
  output logic [NUM_REQ-1:0]            req_data_tvalid,
  output logic [DATA_PORT_SIZE-1:0]     req_data_tdata,
  input  logic [NUM_REQ-1:0]            req_data_tready,
  output logic                          mem_addr_tvalid,
  output logic [TAGS_WIDTH-1:0]         mem_addr_tdata,
  input  logic                          mem_addr_tready,
  input  logic                          mem_data_tvalid,
  input  logic [DATA_PORT_SIZE-1:0]     mem_data_tdata,
  output logic                          mem_data_tready,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                  state_q, state_d;
  logic [GRANT_W-1:0]      last_grant_q, last_grant_d;
  logic [GRANT_W-1:0]      grant_id_q, grant_id_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [TAGS_WIDTH-1:0]   tag_q, tag_d;

  logic                    found;
  logic [GRANT_W-1:0]      cand;
  logic [GRANT_W-1:0]      winner;
  logic                    beat_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      tag_q        <= tag_d;
    end
  end

  // Round-robin search starts just after the previous owner so every way
  // gets a turn before anyone is served twice.
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GRANT_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_addr_tvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign beat_xfer = mem_data_tvalid && req_data_tready[grant_id_q];

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_id_d      = grant_id_q;
    beat_cnt_d      = beat_cnt_q;
    tag_d           = tag_q;
    req_addr_tready = '0;
    req_data_tvalid = '0;
    req_data_tdata  = '0;
    mem_addr_tvalid = 1'b0;
    mem_addr_tdata  = '0;
    mem_data_tready = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_addr_tready[winner] = 1'b1;
          tag_d      = req_addr_tdata[int'(winner)*TAGS_WIDTH +: TAGS_WIDTH];
          grant_id_d = winner;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        mem_addr_tvalid = 1'b1;
        mem_addr_tdata  = tag_q;
        if (mem_addr_tready) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        // Zero-latency pass-through: memory backpressure is exactly the
        // owning way's ready, so memory beats stall rather than drop.
        req_data_tvalid[grant_id_q] = mem_data_tvalid;
        req_data_tdata              = mem_data_tdata;
        mem_data_tready             = req_data_tready[grant_id_q];
        if (beat_xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            last_grant_d = grant_id_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cache_backend_arbiter.sv
// tb_cache_backend_arbiter
//   Directed bench for cache_backend_arbiter configured with four beats per
//   line. Expected tags and beats go into queues when driven and are popped
//   when the arbiter hands them on.
module tb_cache_backend_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int TAGS_WIDTH     = 48;
  localparam int CACHE_SIZE     = 2048;
  localparam int DATA_PORT_SIZE = 512;
  localparam int BEATS          = CACHE_SIZE / DATA_PORT_SIZE;
  localparam int GRANT_W        = $clog2(NUM_REQ);

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_addr_tvalid;
  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata;
  logic [NUM_REQ-1:0]            req_addr_tready;
  logic [NUM_REQ-1:0]            req_data_tvalid;
  logic [DATA_PORT_SIZE-1:0]     req_data_tdata;
  logic [NUM_REQ-1:0]            req_data_tready;
  logic                          mem_addr_tvalid;
  logic [TAGS_WIDTH-1:0]         mem_addr_tdata;
  logic                          mem_addr_tready;
  logic                          mem_data_tvalid;
  logic [DATA_PORT_SIZE-1:0]     mem_data_tdata;
  logic                          mem_data_tready;
  logic [GRANT_W-1:0]            grant_id;
  logic                          busy;

  int errors = 0;
  int checks = 0;

  logic [TAGS_WIDTH-1:0]     exp_addr_q[$];
  logic [DATA_PORT_SIZE-1:0] exp_beat_q[$];
  logic [TAGS_WIDTH-1:0]     tag_of[NUM_REQ];

  cache_backend_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TAGS_WIDTH     (TAGS_WIDTH),
    .CACHE_SIZE     (CACHE_SIZE),
    .DATA_PORT_SIZE (DATA_PORT_SIZE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_addr_tvalid (req_addr_tvalid),
    .req_addr_tdata  (req_addr_tdata),
    .req_addr_tready (req_addr_tready),
    .req_data_tvalid (req_data_tvalid),
    .req_data_tdata  (req_data_tdata),
    .req_data_tready (req_data_tready),
    .mem_addr_tvalid (mem_addr_tvalid),
    .mem_addr_tdata  (mem_addr_tdata),
    .mem_addr_tready (mem_addr_tready),
    .mem_data_tvalid (mem_data_tvalid),
    .mem_data_tdata  (mem_data_tdata),
    .mem_data_tready (mem_data_tready),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_PORT_SIZE-1:0] observed,
                             input logic [DATA_PORT_SIZE-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] av, input logic [NUM_REQ-1:0] dr,
                               input logic mar, input logic mdv,
                               input logic [DATA_PORT_SIZE-1:0] mdd);
    req_addr_tvalid = av;
    req_data_tready = dr;
    mem_addr_tready = mar;
    mem_data_tvalid = mdv;
    mem_data_tdata  = mdd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setTag(input int way, input logic [TAGS_WIDTH-1:0] t);
    tag_of[way] = t;
    req_addr_tdata[way*TAGS_WIDTH +: TAGS_WIDTH] = t;
  endtask

  function automatic logic [NUM_REQ-1:0] oneHot(input int way);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[way] = 1'b1;
    return oh;
  endfunction

  // Idle-side reset check includes a pending memory beat that must stall.
  task automatic doReset;
    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b1, 512'hDEAD);
    tick;
    tick;
    rst = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b1, 512'hDEAD);
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_grant_id", grant_id, '0);
    checkOutput("rst_mem_addr_tvalid", mem_addr_tvalid, 1'b0);
    checkOutput("rst_mem_addr_tdata", mem_addr_tdata, '0);
    checkOutput("rst_req_addr_tready", req_addr_tready, '0);
    checkOutput("rst_mem_data_tready", mem_data_tready, 1'b0);
    checkOutput("rst_req_data_tvalid", req_data_tvalid, '0);
    exp_addr_q.delete();
    exp_beat_q.delete();
  endtask

  // Grant cycle in IDLE: winner's ready is one-hot and combinational.
  task automatic grantStep(input int way, input logic [NUM_REQ-1:0] av);
    applyStimulus(av, '0, 1'b0, 1'b0, '0);
    exp_addr_q.push_back(tag_of[way]);
    #1;
    checkOutput("grant_onehot", req_addr_tready, oneHot(way));
    checkOutput("grant_busy_idle", busy, 1'b0);
    tick;
  endtask

  task automatic addrPhase(input int way, input int stall, input logic [NUM_REQ-1:0] av,
                           input logic mdv);
    logic [TAGS_WIDTH-1:0] e;
    for (int s = 0; s <= stall; s++) begin
      applyStimulus(av, '1, (s == stall), mdv, 512'hBAD);
      #1;
      checkOutput("addr_tvalid", mem_addr_tvalid, 1'b1);
      checkOutput("addr_no_other_ready", req_addr_tready, '0);
      checkOutput("addr_grant_id", grant_id, way);
      checkOutput("addr_data_stalled", mem_data_tready, 1'b0);
      if (exp_addr_q.size() == 0) begin
        checkOutput("addr_queue_nonempty", '0, 1'b1);
      end else if (s == stall) begin
        e = exp_addr_q.pop_front();
        checkOutput("addr_tag", mem_addr_tdata, e);
      end else begin
        checkOutput("addr_tag_stable", mem_addr_tdata, exp_addr_q[0]);
      end
      tick;
    end
  endtask

  task automatic sendBeats(input int way, input logic [DATA_PORT_SIZE-1:0] base,
                           input logic [7:0] readyPat, input logic [NUM_REQ-1:0] av,
                           input logic [NUM_REQ-1:0] avLast);
    int sent;
    int cyc;
    logic rdy;
    logic [NUM_REQ-1:0] oh;
    logic [NUM_REQ-1:0] dr;
    logic [NUM_REQ-1:0] v;
    logic [DATA_PORT_SIZE-1:0] popped;
    sent = 0;
    cyc  = 0;
    oh   = oneHot(way);
    for (int b = 0; b < BEATS; b++) exp_beat_q.push_back(base + DATA_PORT_SIZE'(b));
    while (sent < BEATS && cyc < 16) begin
      rdy = readyPat[cyc % 8];
      dr  = rdy ? '1 : ~oh;
      v   = (sent == BEATS - 1) ? avLast : av;
      applyStimulus(v, dr, 1'b1, 1'b1, base + DATA_PORT_SIZE'(sent));
      #1;
      checkOutput("data_tvalid_route", req_data_tvalid, oh);
      checkOutput("data_tready_follow", mem_data_tready, rdy);
      checkOutput("data_no_addr_ready", req_addr_tready, '0);
      checkOutput("data_busy", busy, 1'b1);
      if (rdy) begin
        popped = exp_beat_q.pop_front();
        checkOutput("beat_data", req_data_tdata, popped);
        sent++;
      end
      tick;
      cyc++;
    end
    checkOutput("beat_count", sent, BEATS);
  endtask

  initial begin
    logic [NUM_REQ*TAGS_WIDTH-1:0] zero_tags;
    logic [DATA_PORT_SIZE-1:0] e;
    int way;
    zero_tags      = '0;
    req_addr_tdata = zero_tags;
    for (int i = 0; i < NUM_REQ; i++) tag_of[i] = '0;

    // T1: single way, full fill, busy drops afterwards
    doReset;
    setTag(0, 48'h1234);
    grantStep(0, 4'b0001);
    addrPhase(0, 0, 4'b0000, 1'b0);
    sendBeats(0, 512'hAB, 8'hFF, 4'b0000, 4'b0000);
    applyStimulus('0, '0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t1_busy_after", busy, 1'b0);
    checkOutput("t1_grant_hold", grant_id, 0);

    // T2: all ways requesting continuously; round-robin 0,1,2,3,0
    doReset;
    for (int i = 0; i < NUM_REQ; i++) setTag(i, 48'hA000 + 48'(i));
    for (int g = 0; g < 5; g++) begin
      way = g % NUM_REQ;
      grantStep(way, 4'b1111);
      setTag(way, tag_of[way] + 48'h10);
      addrPhase(way, 0, 4'b1111, 1'b0);
      sendBeats(way, 512'h100 * (g + 1), 8'hFF, 4'b1111, 4'b1111);
    end

    // T3: ready toggling 1,0,1,0 on way2
    doReset;
    setTag(2, 48'h3333);
    grantStep(2, 4'b0100);
    addrPhase(2, 0, 4'b0000, 1'b0);
    sendBeats(2, 512'h300, 8'b0101_0101, 4'b0000, 4'b0000);
    applyStimulus('0, '0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t3_idle_after", busy, 1'b0);

    // T4: memory address stalled 10 cycles while way3 also waits
    doReset;
    setTag(1, 48'h5555);
    setTag(3, 48'h7777);
    grantStep(1, 4'b1010);
    addrPhase(1, 10, 4'b1000, 1'b0);
    sendBeats(1, 512'h400, 8'hFF, 4'b1000, 4'b1000);

    // T5: reset mid-fill after beat 1 of way3
    grantStep(3, 4'b1000);
    addrPhase(3, 0, 4'b0000, 1'b0);
    exp_beat_q.push_back(512'h500);
    applyStimulus('0, '1, 1'b1, 1'b1, 512'h500);
    #1;
    e = exp_beat_q.pop_front();
    checkOutput("t5_beat0", req_data_tdata, e);
    checkOutput("t5_beat0_valid", req_data_tvalid, 4'b1000);
    tick;
    applyStimulus('0, '1, 1'b1, 1'b1, 512'h501);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    applyStimulus(4'b1111, '1, 1'b1, 1'b1, 512'h501);
    #1;
    checkOutput("t5_busy", busy, 1'b0);
    checkOutput("t5_mem_data_tready", mem_data_tready, 1'b0);
    checkOutput("t5_req_data_tvalid", req_data_tvalid, '0);
    checkOutput("t5_grant_id", grant_id, 0);
    checkOutput("t5_way0_wins", req_addr_tready, 4'b0001);
    tick;

    // T6: way2 raises valid on way1's final beat; one IDLE bubble with stalled memory
    doReset;
    setTag(1, 48'h1111);
    setTag(2, 48'h2222);
    grantStep(1, 4'b0010);
    addrPhase(1, 0, 4'b0000, 1'b0);
    exp_addr_q.push_back(48'h2222);
    sendBeats(1, 512'h600, 8'hFF, 4'b0000, 4'b0100);
    applyStimulus(4'b0100, '1, 1'b0, 1'b1, 512'h700);
    #1;
    checkOutput("t6_bubble_idle", busy, 1'b0);
    checkOutput("t6_way2_grant", req_addr_tready, 4'b0100);
    checkOutput("t6_idle_stall", mem_data_tready, 1'b0);
    checkOutput("t6_idle_no_tvalid", req_data_tvalid, '0);
    tick;
    addrPhase(2, 0, 4'b0000, 1'b1);
    sendBeats(2, 512'h700, 8'hFF, 4'b0000, 4'b0000);
    applyStimulus('0, '0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t6_idle_after", busy, 1'b0);
    checkOutput("t6_queues_drained", exp_addr_q.size() + exp_beat_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
